// File: rtl/sbox_equiv_sweeper.sv
// On-chip equivalence checker: drives a common stimulus into two S-box models,
// aligns their results with a tag pipeline, counts mismatches and latches the first.
module sbox_equiv_sweeper #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 0,
    parameter int ERRW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH:0]   num_vec,
    output logic [WIDTH-1:0] stim,
    input  logic [WIDTH-1:0] res_a,
    input  logic [WIDTH-1:0] res_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_stim,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam logic [15:0] MASK_FULL = (WIDTH == 4) ? 16'h000C :
                                        (WIDTH == 8) ? 16'h00B8 : 16'hB400;
    localparam logic [WIDTH-1:0] MASK = MASK_FULL[WIDTH-1:0];

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             mode_r;
    logic [WIDTH:0]   left;
    logic [WIDTH:0]   total;
    logic [WIDTH-1:0] first;
    logic [WIDTH-1:0] stim_next;
    logic             vld_p0;
    logic             cmp_vld;
    logic [WIDTH-1:0] cmp_stim;
    logic             pipe_busy;

    // Right-shift Galois LFSR step; maximal-length masks never reach zero.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = s >> 1;
        if (s[0])
            r = r ^ MASK;
        return r;
    endfunction

    function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] c);
        return (&c) ? c : c + ERRW'(1);
    endfunction

    assign accept    = start && (state == IDLE || state == DONE);
    assign total     = mode ? num_vec : {1'b1, {WIDTH{1'b0}}};
    assign first     = mode ? ((seed == '0) ? WIDTH'(1) : seed) : '0;
    assign stim_next = mode_r ? lfsr_next(stim) : stim + WIDTH'(1);

    assign busy = (state == DRIVE) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start)
                    state_nxt = (total == '0) ? DRAIN : DRIVE;
            end
            DRIVE: begin
                if (left == '0)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!pipe_busy)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 0: vector issue. vld_p0 marks that stim carries a vector to be compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            stim       <= '0;
            vld_p0     <= 1'b0;
            left       <= '0;
            mode_r     <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_stim  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else if (accept) begin
            mode_r     <= mode;
            stim       <= first;
            vld_p0     <= (total != '0);
            left       <= total - (WIDTH+1)'(1);
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_stim  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            if (state == DRIVE) begin
                if (left == '0) begin
                    vld_p0 <= 1'b0;
                end else begin
                    stim <= stim_next;
                    left <= left - (WIDTH+1)'(1);
                end
            end
            if (cmp_vld && (res_a != res_b)) begin
                err_count <= sat_inc(err_count);
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    fail_stim  <= cmp_stim;
                    fail_a     <= res_a;
                    fail_b     <= res_b;
                end
            end
        end
    end

    // Stages 1..LATENCY: tag delay matching the models' pipeline depth.
    generate
        if (LATENCY == 0) begin : g_comb
            assign cmp_vld   = vld_p0;
            assign cmp_stim  = stim;
            assign pipe_busy = vld_p0;
        end else begin : g_pipe
            logic [LATENCY-1:0]            vld_pn;
            logic [LATENCY-1:0][WIDTH-1:0] tag_pn;

            always_ff @(posedge clk) begin
                if (rst)
                    vld_pn <= '0;
                else
                    vld_pn <= (vld_pn << 1) | LATENCY'(vld_p0);
            end

            always_ff @(posedge clk) begin
                tag_pn <= (tag_pn << WIDTH) | (LATENCY*WIDTH)'(stim);
            end

            assign cmp_vld   = vld_pn[LATENCY-1];
            assign cmp_stim  = tag_pn[LATENCY-1];
            assign pipe_busy = vld_p0 | (|vld_pn);
        end
    endgenerate

endmodule

// File: doc/sbox_equiv_sweeper.md
# sbox_equiv_sweeper

Parametrised on-chip equivalence checker for the S-box datapath. It drives a stimulus bus into two field-mapping implementations under comparison, for example the isomorphic map and the change-of-basis map, and accounts for their pipeline latency. It compares their outputs every cycle, counts mismatches and latches the first failing vector. It supports an exhaustive sweep of all 2^WIDTH inputs and an LFSR pseudo-random sweep, so the same engine serves GF(2^4) subfield blocks and 16-bit datapaths.

## Interface
- WIDTH, 8: stimulus/result width; legal values 4, 8, 16 only.
- LATENCY, 0: cycles from a stim change to the matching res_a/res_b being valid; 0 = purely combinational models.
- ERRW, 16: width of err_count.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse, begins a sweep when idle.
- mode  in  1  0 = exhaustive, 1 = LFSR.
- seed  in  WIDTH  LFSR start value, sampled at start; 0 is replaced by 1.
- num_vec  in  WIDTH+1  vector count for LFSR mode, sampled at start; ignored in exhaustive mode.
- stim  out  WIDTH  registered stimulus driven to both models.
- res_a  in  WIDTH  output of model A.
- res_b  in  WIDTH  output of model B (golden).
- busy  out  1  high from the start edge until done.
- done  out  1  level; high after a sweep completes, cleared by the next accepted start or rst.
- pass  out  1  valid while done=1; 1 if err_count == 0.
- err_count  out  ERRW  mismatch count, saturating at 2^ERRW-1.
- fail_valid  out  1  a first failure has been latched.
- fail_stim, fail_a, fail_b  out  WIDTH each  stim, res_a and res_b of the first mismatch.

## Operation
- FSM states: IDLE, DRIVE, DRAIN, DONE.
- IDLE/DONE + start=1 moves to DRIVE. The start edge clears err_count, fail_*, done and pass, samples mode, seed and num_vec, and loads stim with the first vector.
- First vector: 0 in exhaustive mode; seed (or 1 if seed=0) in LFSR mode.
- DRIVE issues one vector per cycle. Total vectors are 2^WIDTH in exhaustive mode (0,1,…,2^WIDTH-1, stim increments) or num_vec in LFSR mode.
- LFSR next state is right-shift Galois: lsb = s[0]; s = s >> 1; if lsb, s ^= MASK.
  - MASK = 0xC for WIDTH 4, 0xB8 for WIDTH 8, 0xB400 for WIDTH 16.
  - The sequence is maximal length and never produces 0. It repeats after 2^WIDTH-1 vectors when num_vec exceeds that.
- The last vector is issued, then DRIVE moves to DRAIN. DRAIN holds stim at the last vector until every issued vector has been compared, then moves to DONE.
- A tag pipeline of LATENCY+1 stages carries (valid, stim) alongside the models. A compare happens at an edge where the tag's valid is 1, and counts a mismatch if res_a != res_b.
- On each mismatch, err_count increments, saturating at all-ones. If fail_valid=0, the block latches fail_stim = tag stim, fail_a = res_a, fail_b = res_b, and sets fail_valid. Later mismatches do not overwrite the latch.
- LFSR mode with num_vec=0: the block goes straight to DONE with no compares, pass=1, err_count=0. Busy is high for exactly 1 cycle.
- start is ignored while busy=1.
- rst at any time returns to IDLE. Reset values: stim=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_*=0, tag pipeline valid bits cleared.

## Timing
- Start sampled at edge E0: busy=1 and stim = first vector after E0.
- Vector i appears on stim after edge E0+i.
- Its compare happens at edge E0+i+LATENCY+1.
- With N vectors, the last compare is at E0+N+LATENCY. DONE is entered and done=1, busy=0 after edge E0+N+LATENCY+1.
- Total busy cycles = N+LATENCY+1.
- Exhaustive WIDTH=8, LATENCY=0: 257 busy cycles.
- pass and err_count are stable when done rises.
- done stays high until the cycle after the next accepted start edge.

## Test plan
- WIDTH=8, LATENCY=0, mode=0, res_a=res_b=f(stim) -> stim walks 0..255, done after 257 busy cycles, pass=1, err_count=0, fail_valid=0.
- Same, but model A corrupted so that stim 0x53 and 0xCA produce bit0 flipped -> err_count=2, fail_stim=0x53, fail_a=fail_b^0x01, pass=0.
- WIDTH=8, LATENCY=3, two 3-stage piped models, one fault at stim 0x00 -> fail_stim=0x00, busy cycles = 260. Also check no compare occurs on the stale pipeline contents.
- WIDTH=8, mode=1, seed=0x00, num_vec=5 -> stim sequence 0x01,0xB8,0x5C,0x2E,0x17, done after 6 busy cycles. Separately, num_vec=0 -> done after 1 cycle, pass=1.
- WIDTH=4, mode=1, seed=1, num_vec=16, always-mismatching model -> 15 distinct nonzero stims then a repeat of 1. err_count=16, fail_stim=1.
- rst asserted at vector 100 of an exhaustive run, then start re-pulsed -> all outputs at reset values the cycle after rst, and the new run completes normally. A start pulse mid-run is ignored, and the run's stim sequence is unchanged.
